bsg_mul_product_serializer: RTL and testbench



---
 rtl/bsg_mul_product_serializer_if.sv | 27 ++
 rtl/bsg_mul_product_serializer.sv | 91 +++++++++
 tb/tb_bsg_mul_product_serializer.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/bsg_mul_product_serializer_if.sv
// Handshake bundle between the multiplier, the product serializer and the beat consumer.
//   v_i / z_i / ready_o        : product intake (valid/ready)
//   v_o / data_o / last_o / yumi_i : beat output (valid/yumi)
// slave  : serializer view
// master : environment view (drives products and yumi, observes beats)
interface bsg_mul_product_serializer_if #(
    parameter int unsigned width_p      = 128,
    parameter int unsigned beat_width_p = 64
);
    logic                    v_i;
    logic [2*width_p-1:0]    z_i;
    logic                    ready_o;
    logic                    v_o;
    logic [beat_width_p-1:0] data_o;
    logic                    last_o;
    logic                    yumi_i;

    modport slave (
        input  v_i, z_i, yumi_i,
        output ready_o, v_o, data_o, last_o
    );

    modport master (
        output v_i, z_i, yumi_i,
        input  ready_o, v_o, data_o, last_o
    );
endinterface

// File: rtl/bsg_mul_product_serializer.sv
// Captures one 2*width_p-bit product and streams it out as beat_width_p-bit beats.
// A new product can be accepted in the same cycle the final beat is taken.
// Ports:
//   clk_i   : clock, all state changes on its rising edge
//   reset_i : synchronous active-high reset
//   bus     : product intake (v_i, z_i, ready_o) and beat output (v_o, data_o, last_o, yumi_i)
module bsg_mul_product_serializer #(
    parameter int unsigned width_p      = 128,
    parameter int unsigned beat_width_p = 64,
    parameter int unsigned lsb_first_p  = 1
) (
    input  logic clk_i,
    input  logic reset_i,
    bsg_mul_product_serializer_if.slave bus
);

    localparam int unsigned prod_width_lp = 2 * width_p;
    localparam int unsigned num_beats_lp  = prod_width_lp / beat_width_p;
    localparam int unsigned cnt_width_lp  = (num_beats_lp > 2) ? $clog2(num_beats_lp) : 1;

    typedef enum logic {
        e_idle = 1'b0,
        e_send = 1'b1
    } state_e;

    state_e                    state_r;
    logic [prod_width_lp-1:0]  product_r;
    logic [cnt_width_lp-1:0]   cnt_r;
    logic [cnt_width_lp-1:0]   cnt_inc;
    logic                      v_r;
    logic                      last_r;
    logic [beat_width_p-1:0]   data_r;
    logic                      handoff;
    logic                      accept;

    // Pick beat c of a product, honouring the configured beat order.
    function automatic logic [beat_width_p-1:0] beat_sel(
        input logic [prod_width_lp-1:0] p,
        input logic [cnt_width_lp-1:0]  c
    );
        int unsigned idx;
        idx = (lsb_first_p != 0) ? 32'(c) : (num_beats_lp - 1 - 32'(c));
        return beat_width_p'(p >> (idx * beat_width_p));
    endfunction

    assign cnt_inc = cnt_r + cnt_width_lp'(1);

    // Final beat leaving this cycle frees the product register for the next product.
    assign handoff = v_r & last_r & bus.yumi_i;
    assign accept  = bus.v_i & bus.ready_o;

    assign bus.ready_o = (state_r == e_idle) | handoff;
    assign bus.v_o     = v_r;
    assign bus.last_o  = last_r;
    assign bus.data_o  = data_r;

    // FSM, beat counter and registered beat outputs.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_r <= e_idle;
            cnt_r   <= '0;
            v_r     <= 1'b0;
            last_r  <= 1'b0;
            data_r  <= '0;
        end else if (accept) begin
            // Covers both the idle load and the zero-bubble handoff load.
            product_r <= bus.z_i;
            cnt_r     <= '0;
            state_r   <= e_send;
            v_r       <= 1'b1;
            last_r    <= 1'b0;
            data_r    <= beat_sel(bus.z_i, '0);
        end else if ((state_r == e_send) && bus.yumi_i) begin
            if (last_r) begin
                state_r <= e_idle;
                v_r     <= 1'b0;
                last_r  <= 1'b0;
            end else begin
                cnt_r  <= cnt_inc;
                data_r <= beat_sel(product_r, cnt_inc);
                last_r <= (cnt_inc == cnt_width_lp'(num_beats_lp - 1));
            end
        end
    end

    // A consumer must never take a beat that is not being offered.
    yumi_without_valid: assert property (@(posedge clk_i) disable iff (reset_i)
        bus.yumi_i |-> v_r)
        else $error("yumi_i asserted while v_o is low");

endmodule

// File: tb/tb_bsg_mul_product_serializer.sv
module tb_bsg_mul_product_serializer;

    logic clk;
    logic reset;
    int   total;
    int   bad;

    logic [63:0]  a_beats [4];
    logic [63:0]  b_beats [4];
    logic [255:0] za;
    logic [255:0] zb;

    bsg_mul_product_serializer_if #(.width_p(128), .beat_width_p(64)) bus_l ();
    bsg_mul_product_serializer_if #(.width_p(128), .beat_width_p(64)) bus_m ();

    bsg_mul_product_serializer #(.width_p(128), .beat_width_p(64), .lsb_first_p(1)) dut_l (
        .clk_i   (clk),
        .reset_i (reset),
        .bus     (bus_l.slave)
    );

    bsg_mul_product_serializer #(.width_p(128), .beat_width_p(64), .lsb_first_p(0)) dut_m (
        .clk_i   (clk),
        .reset_i (reset),
        .bus     (bus_m.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change on the falling edge; outputs are checked 1ns later.
    task automatic drive_l(input logic v, input logic [255:0] z, input logic y);
        @(negedge clk);
        bus_l.v_i    = v;
        bus_l.z_i    = z;
        bus_l.yumi_i = y;
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        for (int i = 0; i < 2; i++) begin
            drive_l(1'b0, '0, 1'b0);
            total++;
            if (bus_l.v_o !== 1'b0 || bus_l.last_o !== 1'b0 || bus_l.ready_o !== 1'b1) begin
                bad++;
                $display("FAIL reset_in: v=%b last=%b ready=%b want v=0 last=0 ready=1",
                         bus_l.v_o, bus_l.last_o, bus_l.ready_o);
            end
        end
        reset = 1'b0;
        for (int i = 0; i < 2; i++) begin
            drive_l(1'b0, '0, 1'b0);
            total++;
            if (bus_l.v_o !== 1'b0 || bus_l.last_o !== 1'b0 || bus_l.ready_o !== 1'b1) begin
                bad++;
                $display("FAIL reset_after: v=%b last=%b ready=%b want v=0 last=0 ready=1",
                         bus_l.v_o, bus_l.last_o, bus_l.ready_o);
            end
        end
        total++;
        if (bus_m.v_o !== 1'b0 || bus_m.ready_o !== 1'b1) begin
            bad++;
            $display("FAIL reset_msb: v=%b ready=%b want v=0 ready=1", bus_m.v_o, bus_m.ready_o);
        end
    endtask

    task automatic test_single();
        drive_l(1'b1, za, 1'b0);
        total++;
        if (bus_l.ready_o !== 1'b1) begin
            bad++;
            $display("FAIL single_ready_t: got %b want 1", bus_l.ready_o);
        end
        for (int k = 0; k < 4; k++) begin
            drive_l(1'b0, '0, 1'b1);
            total++;
            if (bus_l.v_o !== 1'b1 || bus_l.data_o !== a_beats[k] ||
                bus_l.last_o !== (k == 3) || bus_l.ready_o !== (k == 3)) begin
                bad++;
                $display("FAIL single_beat%0d: v=%b data=%h last=%b ready=%b want v=1 data=%h last=%b ready=%b",
                         k, bus_l.v_o, bus_l.data_o, bus_l.last_o, bus_l.ready_o,
                         a_beats[k], (k == 3), (k == 3));
            end
        end
        drive_l(1'b0, '0, 1'b0);
        total++;
        if (bus_l.v_o !== 1'b0 || bus_l.last_o !== 1'b0 || bus_l.ready_o !== 1'b1) begin
            bad++;
            $display("FAIL single_end: v=%b last=%b ready=%b want v=0 last=0 ready=1",
                     bus_l.v_o, bus_l.last_o, bus_l.ready_o);
        end
    endtask

    task automatic test_back_to_back();
        logic [63:0] exp;
        drive_l(1'b1, za, 1'b0);
        total++;
        if (bus_l.ready_o !== 1'b1) begin
            bad++;
            $display("FAIL b2b_ready_t: got %b want 1", bus_l.ready_o);
        end
        for (int i = 0; i < 8; i++) begin
            // B is offered and held from right after A's accept until A3's handoff.
            drive_l(i <= 3, zb, 1'b1);
            exp = (i < 4) ? a_beats[i] : b_beats[i - 4];
            total++;
            if (bus_l.v_o !== 1'b1 || bus_l.data_o !== exp ||
                bus_l.last_o !== ((i % 4) == 3) || bus_l.ready_o !== ((i % 4) == 3)) begin
                bad++;
                $display("FAIL b2b_beat%0d: v=%b data=%h last=%b ready=%b want v=1 data=%h last=%b ready=%b",
                         i, bus_l.v_o, bus_l.data_o, bus_l.last_o, bus_l.ready_o,
                         exp, ((i % 4) == 3), ((i % 4) == 3));
            end
        end
        drive_l(1'b0, '0, 1'b0);
        total++;
        if (bus_l.v_o !== 1'b0 || bus_l.ready_o !== 1'b1) begin
            bad++;
            $display("FAIL b2b_end: v=%b ready=%b want v=0 ready=1", bus_l.v_o, bus_l.ready_o);
        end
    endtask

    task automatic test_backpressure();
        drive_l(1'b1, za, 1'b0);
        for (int k = 0; k < 2; k++) begin
            drive_l(1'b0, '0, 1'b1);
            total++;
            if (bus_l.data_o !== a_beats[k]) begin
                bad++;
                $display("FAIL bp_pre%0d: data=%h want %h", k, bus_l.data_o, a_beats[k]);
            end
        end
        for (int s = 0; s < 5; s++) begin
            drive_l(1'b0, '0, 1'b0);
            total++;
            if (bus_l.v_o !== 1'b1 || bus_l.data_o !== a_beats[2] ||
                bus_l.last_o !== 1'b0 || bus_l.ready_o !== 1'b0) begin
                bad++;
                $display("FAIL bp_stall%0d: v=%b data=%h last=%b ready=%b want v=1 data=%h last=0 ready=0",
                         s, bus_l.v_o, bus_l.data_o, bus_l.last_o, bus_l.ready_o, a_beats[2]);
            end
        end
        drive_l(1'b0, '0, 1'b1);
        total++;
        if (bus_l.data_o !== a_beats[2] || bus_l.last_o !== 1'b0) begin
            bad++;
            $display("FAIL bp_take2: data=%h last=%b want %h last=0", bus_l.data_o, bus_l.last_o, a_beats[2]);
        end
        drive_l(1'b0, '0, 1'b1);
        total++;
        if (bus_l.v_o !== 1'b1 || bus_l.data_o !== a_beats[3] || bus_l.last_o !== 1'b1) begin
            bad++;
            $display("FAIL bp_beat3: v=%b data=%h last=%b want v=1 data=%h last=1",
                     bus_l.v_o, bus_l.data_o, bus_l.last_o, a_beats[3]);
        end
        drive_l(1'b0, '0, 1'b0);
        total++;
        if (bus_l.v_o !== 1'b0) begin
            bad++;
            $display("FAIL bp_end: v=%b want 0", bus_l.v_o);
        end
    endtask

    task automatic test_reset_mid();
        drive_l(1'b1, za, 1'b0);
        drive_l(1'b0, '0, 1'b1);
        drive_l(1'b0, '0, 1'b1);
        // Beat 2 now offered; reset must win over a simultaneous new product and yumi.
        drive_l(1'b1, zb, 1'b1);
        reset = 1'b1;
        drive_l(1'b0, '0, 1'b0);
        reset = 1'b0;
        total++;
        if (bus_l.v_o !== 1'b0 || bus_l.last_o !== 1'b0 || bus_l.ready_o !== 1'b1) begin
            bad++;
            $display("FAIL rstmid_after: v=%b last=%b ready=%b want v=0 last=0 ready=1",
                     bus_l.v_o, bus_l.last_o, bus_l.ready_o);
        end
        drive_l(1'b1, zb, 1'b0);
        for (int k = 0; k < 4; k++) begin
            drive_l(1'b0, '0, 1'b1);
            total++;
            if (bus_l.v_o !== 1'b1 || bus_l.data_o !== b_beats[k] || bus_l.last_o !== (k == 3)) begin
                bad++;
                $display("FAIL rstmid_beat%0d: v=%b data=%h last=%b want v=1 data=%h last=%b",
                         k, bus_l.v_o, bus_l.data_o, bus_l.last_o, b_beats[k], (k == 3));
            end
        end
        drive_l(1'b0, '0, 1'b0);
    endtask

    task automatic test_msb_first();
        @(negedge clk);
        bus_m.v_i    = 1'b1;
        bus_m.z_i    = za;
        bus_m.yumi_i = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            bus_m.v_i    = 1'b0;
            bus_m.yumi_i = 1'b1;
            #1;
            total++;
            if (bus_m.v_o !== 1'b1 || bus_m.data_o !== a_beats[3 - k] || bus_m.last_o !== (k == 3)) begin
                bad++;
                $display("FAIL msb_beat%0d: v=%b data=%h last=%b want v=1 data=%h last=%b",
                         k, bus_m.v_o, bus_m.data_o, bus_m.last_o, a_beats[3 - k], (k == 3));
            end
        end
        @(negedge clk);
        bus_m.yumi_i = 1'b0;
        #1;
        total++;
        if (bus_m.v_o !== 1'b0 || bus_m.ready_o !== 1'b1) begin
            bad++;
            $display("FAIL msb_end: v=%b ready=%b want v=0 ready=1", bus_m.v_o, bus_m.ready_o);
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        a_beats[0] = 64'h0123_4567_89AB_CDEF;
        a_beats[1] = 64'h1000_0000_0000_0001;
        a_beats[2] = 64'h2222_2222_2222_2222;
        a_beats[3] = 64'hF333_0000_0000_3333;
        b_beats[0] = 64'hB0B0_B0B0_0000_000B;
        b_beats[1] = 64'h8000_0000_0000_0000;
        b_beats[2] = 64'h0000_0000_FFFF_FFFF;
        b_beats[3] = 64'hDEAD_BEEF_CAFE_F00D;
        za = {a_beats[3], a_beats[2], a_beats[1], a_beats[0]};
        zb = {b_beats[3], b_beats[2], b_beats[1], b_beats[0]};
        reset        = 1'b1;
        bus_l.v_i    = 1'b0;
        bus_l.z_i    = '0;
        bus_l.yumi_i = 1'b0;
        bus_m.v_i    = 1'b0;
        bus_m.z_i    = '0;
        bus_m.yumi_i = 1'b0;

        test_reset();
        test_single();
        test_back_to_back();
        test_backpressure();
        test_reset_mid();
        test_msb_first();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
